// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU / mux select codes and the packed control word driven by the FSM.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ERROR     = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_B_RT      = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RSVD   = 2'b11
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
  } ctrl_t;

  // States in which the FSM stalls on the memory handshake.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout compare. Counts consecutive stalled cycles
// in a wait state; flags a timeout on the WAIT_TIMEOUT-th stalled cycle unless
// ready arrives in that same cycle. WAIT_TIMEOUT=0 removes the timer entirely.
module mem_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  input  logic restart,
  output logic timeout
);

  generate
    if (WAIT_TIMEOUT > 0) begin : g_timer
      localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);
      localparam logic [CW-1:0] ONE  = CW'(1);

      logic [CW-1:0] count;

      // Count stalled cycles; any handshake or state change starts over.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count <= '0;
        end else if (!active || ready || restart) begin
          count <= '0;
        end else begin
          count <= count + ONE;
        end
      end

      assign timeout = active && !ready && (count == LAST);
    end else begin : g_no_timer
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS datapath controller with memory-ready handshake, wait
// timeout and retired-instruction counter.
// Optional macro ILLEGAL_OPCODE_TRAP_EN: unsupported opcodes lock the FSM in
// TRAP and raise illegal_op_o; otherwise they retire as a NOP.
//
// state     | meaning
// IDLE      | out of reset, all controls low
// FETCH     | read instruction at PC, PC+4 on ready
// DECODE    | compute branch target, dispatch on opcode
// MEM_ADDR  | rs + imm for lw/sw
// MEM_READ  | data read, wait for ready
// MEM_WB    | MDR -> rt
// MEM_WRITE | data write, wait for ready
// EXECUTE   | R-type ALU op
// R_WB      | ALUOut -> rd
// I_EXEC    | addi/ori ALU op
// I_WB      | ALUOut -> rt
// BRANCH    | compare rs/rt, conditional PC load
// JUMP      | PC <- jump target
// ERROR     | memory timeout, locked until reset
// TRAP      | illegal opcode, locked until reset
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 pc_write_cond_o,
  output logic                 branch_ne_o,
  output logic                 i_or_d_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 ir_write_o,
  output logic                 mem_to_reg_o,
  output logic                 reg_dst_o,
  output logic                 reg_write_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic [1:0]           pc_source_o,
  output logic [3:0]           state_o,
  output logic                 bus_error_o,
  output logic [CNT_WIDTH-1:0] instr_count_o
`ifdef ILLEGAL_OPCODE_TRAP_EN
  ,
  output logic                 illegal_op_o
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   timeout;
  logic   retire;

  mem_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (is_wait_state(state)),
    .ready   (mem_ready_i),
    .restart (state_next != state),
    .timeout (timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ready beats a timeout landing in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i)  state_next = S_DECODE;
        else if (timeout) state_next = S_ERROR;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:    state_next = S_MEM_ADDR;
          OP_RTYPE:        state_next = S_EXECUTE;
          OP_ADDI, OP_ORI: state_next = S_I_EXEC;
          OP_BEQ, OP_BNE:  state_next = S_BRANCH;
          OP_J:            state_next = S_JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:         state_next = S_TRAP;
`else
          default:         state_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready_i)  state_next = S_MEM_WB;
        else if (timeout) state_next = S_ERROR;
      end
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready_i)  state_next = S_FETCH;
        else if (timeout) state_next = S_ERROR;
      end
      S_EXECUTE:   state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_I_EXEC:    state_next = S_I_WB;
      S_I_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_ERROR:     state_next = S_ERROR;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_IDLE;
    endcase
  end

  // Control outputs; only FETCH looks at mem_ready_i (IR/PC load on ready).
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE:    ctrl.alu_src_b = SRC_B_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_I_WB:      ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.branch_ne     = (opcode_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default:     ctrl = '0;
    endcase
  end

  // Every return to FETCH from a working state retires one instruction.
  assign retire = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_o <= '0;
    end else if (retire) begin
      instr_count_o <= instr_count_o + CNT_ONE;
    end
  end

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign branch_ne_o     = ctrl.branch_ne;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ctrl.alu_op;
  assign pc_source_o     = ctrl.pc_source;
  assign state_o         = state;
  assign bus_error_o     = (state == S_ERROR);
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign illegal_op_o    = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (WAIT_TIMEOUT=4, CNT_WIDTH=4).
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int unsigned WT = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = 6'h00;
  logic          mem_ready = 1'b1;
  logic          pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic [2:0]    alu_op;
  logic [3:0]    state;
  logic          bus_error;
  logic [CW-1:0] instr_count;
  logic          illegal_op;

  multicycle_control #(.WAIT_TIMEOUT(WT), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .branch_ne_o     (branch_ne),
    .i_or_d_o        (i_or_d),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source),
    .state_o         (state),
    .bus_error_o     (bus_error),
    .instr_count_o   (instr_count)
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    .illegal_op_o    (illegal_op)
`endif
  );

`ifndef ILLEGAL_OPCODE_TRAP_EN
  assign illegal_op = 1'b0;
`endif

  always #5 clk = ~clk;

  logic [17:0] ctrl_act;
  assign ctrl_act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source};

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    state_t     st;
  } vec_t;

  typedef struct {
    state_t        st;
    logic [17:0]   ctrl;
    logic          berr;
    logic [CW-1:0] cnt;
    logic          ill;
  } exp_t;

  vec_t          tbl[$];
  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] cnt_model = '0;
  state_t        last_st = S_IDLE;

  // Expected control word for a state, straight from the output table.
  function automatic logic [17:0] ctl_of(state_t s, logic [5:0] op, logic rdy);
    logic pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] src_b, ps;
    logic [2:0] ao;
    {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
    src_b = 2'b00; ps = 2'b00; ao = 3'b000;
    case (s)
      S_FETCH:     begin mr = 1; src_b = 2'b01; pw = rdy; irw = rdy; end
      S_DECODE:    src_b = 2'b11;
      S_MEM_ADDR:  begin sa = 1; src_b = 2'b10; end
      S_MEM_READ:  begin mr = 1; iod = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: begin mw = 1; iod = 1; end
      S_EXECUTE:   begin sa = 1; ao = 3'b010; end
      S_R_WB:      begin rw = 1; rd = 1; end
      S_I_EXEC:    begin sa = 1; src_b = 2'b10; ao = (op == 6'h0D) ? 3'b011 : 3'b000; end
      S_I_WB:      rw = 1;
      S_BRANCH:    begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; bne = (op == 6'h05); end
      S_JUMP:      begin pw = 1; ps = 2'b10; end
      default:     ;
    endcase
    return {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, sa, src_b, ao, ps};
  endfunction

  function automatic void add(logic [5:0] op, logic rdy, state_t st);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st;
    tbl.push_back(v);
  endfunction

  task automatic check_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (state !== e.st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", tag, state, e.st);
    end
    checks++;
    if (ctrl_act !== e.ctrl) begin
      errors++;
      $display("FAIL %s ctrl: got %b want %b", tag, ctrl_act, e.ctrl);
    end
    checks++;
    if (bus_error !== e.berr || instr_count !== e.cnt || illegal_op !== e.ill) begin
      errors++;
      $display("FAIL %s status: got berr=%b cnt=%0d ill=%b want berr=%b cnt=%0d ill=%b",
               tag, bus_error, instr_count, illegal_op, e.berr, e.cnt, e.ill);
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks it at the falling edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    opcode    = v.op;
    mem_ready = v.rdy;
    if (v.st == S_FETCH && last_st != S_FETCH && last_st != S_IDLE)
      cnt_model = cnt_model + CW'(1);
    last_st = v.st;
    e.st   = v.st;
    e.ctrl = ctl_of(v.st, v.op, v.rdy);
    e.berr = (v.st == S_ERROR);
    e.cnt  = cnt_model;
    e.ill  = (v.st == S_TRAP);
    sb.push_back(e);
    @(negedge clk);
    check_front(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  // Asynchronous reset mid-cycle: checked immediately, released after the next edge.
  task automatic pulse_reset(input string tag);
    exp_t e;
    reset = 1'b0;
    #1;
    e.st = S_IDLE; e.ctrl = '0; e.berr = 1'b0; e.cnt = '0; e.ill = 1'b0;
    sb.push_back(e);
    check_front(tag);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    cnt_model = '0;
    last_st   = S_IDLE;
  endtask

  initial begin
    #3;
    pulse_reset("reset");

    // Main instruction mix, ready low in some memory cycles.
    add(6'h00, 1, S_IDLE);
    add(6'h00, 1, S_FETCH);    add(6'h00, 1, S_DECODE);  add(6'h00, 1, S_EXECUTE);
    add(6'h00, 1, S_R_WB);
    add(6'h00, 1, S_FETCH);    add(6'h23, 1, S_DECODE);  add(6'h23, 1, S_MEM_ADDR);
    add(6'h23, 0, S_MEM_READ); add(6'h23, 0, S_MEM_READ); add(6'h23, 0, S_MEM_READ);
    add(6'h23, 1, S_MEM_READ); add(6'h23, 1, S_MEM_WB);
    add(6'h23, 1, S_FETCH);    add(6'h2B, 0, S_DECODE);  add(6'h2B, 0, S_MEM_ADDR);
    add(6'h2B, 0, S_MEM_WRITE); add(6'h2B, 1, S_MEM_WRITE);
    add(6'h2B, 0, S_FETCH);    add(6'h2B, 0, S_FETCH);   add(6'h2B, 1, S_FETCH);
    add(6'h08, 1, S_DECODE);   add(6'h08, 1, S_I_EXEC);  add(6'h08, 0, S_I_WB);
    add(6'h08, 1, S_FETCH);    add(6'h0D, 1, S_DECODE);  add(6'h0D, 1, S_I_EXEC);
    add(6'h0D, 1, S_I_WB);
    add(6'h0D, 1, S_FETCH);    add(6'h04, 1, S_DECODE);  add(6'h04, 1, S_BRANCH);
    add(6'h04, 1, S_FETCH);    add(6'h05, 1, S_DECODE);  add(6'h05, 1, S_BRANCH);
    add(6'h05, 1, S_FETCH);    add(6'h02, 1, S_DECODE);  add(6'h02, 1, S_JUMP);
    add(6'h02, 1, S_FETCH);    add(6'h3F, 1, S_DECODE);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    add(6'h3F, 1, S_TRAP);     add(6'h00, 1, S_TRAP);
`else
    add(6'h3F, 0, S_FETCH);    add(6'h3F, 0, S_FETCH);
`endif
    run_table("mix");

    // Fetch timeout: 4 stalled cycles, then locked in ERROR until reset.
    pulse_reset("reset_pre_timeout");
    add(6'h00, 0, S_IDLE);
    for (int i = 0; i < 4; i++) add(6'h00, 0, S_FETCH);
    add(6'h00, 0, S_ERROR);    add(6'h00, 1, S_ERROR);   add(6'h23, 1, S_ERROR);
    run_table("timeout");
    pulse_reset("reset_clears_error");
    add(6'h00, 1, S_IDLE);     add(6'h00, 1, S_FETCH);   add(6'h00, 1, S_DECODE);
    run_table("after_error");

    // Counter wrap: 16 jumps on a 4-bit counter.
    pulse_reset("reset_pre_wrap");
    add(6'h00, 1, S_IDLE);
    for (int i = 0; i < 16; i++) begin
      add(6'h02, 1, S_FETCH);  add(6'h02, 1, S_DECODE);  add(6'h02, 1, S_JUMP);
    end
    add(6'h02, 1, S_FETCH);    add(6'h02, 1, S_DECODE);
    run_table("wrap");
    checks++;
    if (state !== S_JUMP || instr_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_mid_jump: got state=%0d cnt=%0d want state=%0d cnt=0",
               state, instr_count, S_JUMP);
    end
    pulse_reset("reset_mid_jump");
    add(6'h00, 1, S_IDLE);     add(6'h00, 1, S_FETCH);
    run_table("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multi-cycle MIPS datapath.
- Reuses one ALU and one unified instruction/data memory across several cycles per instruction.
- Replaces the single-cycle opcode decoder.
- Adds a memory-ready handshake, a wait timeout and a retired-instruction counter.

Parameters:
- WAIT_TIMEOUT, 15: max cycles waiting for mem_ready_i before bus error; 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- opcode_i  in  6  instruction register [31:26]
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  conditional PC load (branch)
- branch_ne_o  out  1  1 = bne sense, 0 = beq sense
- i_or_d_o  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  instruction register load
- mem_to_reg_o  out  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_dst_o  out  1  destination register: 0 = rt, 1 = rd
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  ALU A source: 0 = PC, 1 = rs
- alu_src_b_o  out  2  ALU B source: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op_o  out  3  000 = add, 001 = sub, 010 = funct, 011 = or
- pc_source_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- state_o  out  4  current state encoding
- bus_error_o  out  1  sticky timeout flag
- instr_count_o  out  CNT_WIDTH  retired instructions

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; wait counter=0; instr_count_o=0; bus_error_o=0.
  - All control outputs 0.
- IDLE: all outputs 0; next cycle goes to FETCH.
- Supported opcodes:
  - R-type 0x00, addi 0x08, ori 0x0D, beq 0x04, bne 0x05, lw 0x23, sw 0x2B, j 0x02.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready_i=1 (Mealy); the FSM then moves to DECODE.
  - Otherwise the FSM holds FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add. Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R-type -> EXECUTE
  - addi/ori -> I_EXEC
  - beq/bne -> BRANCH
  - j -> JUMP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add; lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; holds until mem_ready_i, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; holds until mem_ready_i, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=funct; -> R_WB.
- R_WB: reg_write=1, reg_dst=1; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=add (addi) or or (ori); -> I_WB.
- I_WB: reg_write=1, reg_dst=0; -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01.
  - branch_ne=1 for bne, 0 for beq.
  - -> FETCH.
- JUMP: pc_write=1, pc_source=10; -> FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready_i=0.
  - Clears on mem_ready_i=1 or on any state change.
  - If WAIT_TIMEOUT>0 and the count reaches WAIT_TIMEOUT with mem_ready_i still 0, the FSM goes to ERROR.
  - mem_ready_i=1 in the same cycle as the limit wins; no error.
- ERROR:
  - All control outputs 0; bus_error_o=1.
  - Stays in ERROR until reset.
- instr_count_o:
  - Increments by 1 in the cycle the FSM leaves MEM_WB, MEM_WRITE (ready), R_WB, I_WB, BRANCH or JUMP to FETCH.
  - Wraps to 0 after 2^CNT_WIDTH-1.
- Unsupported opcode in DECODE: behaviour per the optional feature below.
- mem_ready_i asserted outside memory states: ignored.
- Reset asserted mid-instruction: immediate return to IDLE; counter and flag cleared.

Optional Feature:
- Macro ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE goes to TRAP, which drives all outputs 0.
  - Adds output illegal_op_o=1 while in TRAP.
  - TRAP stays until reset; instr_count_o does not increment.
- Undefined:
  - An unsupported opcode returns DECODE -> FETCH, acting as a NOP.
  - The PC has already advanced in FETCH.
  - instr_count_o increments.
  - No illegal_op_o port.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants
  - state encoding enum (IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ERROR, TRAP)
  - alu_op, alu_src_b and pc_source encodings
- One sub-module, mem_wait_timer: wait counter plus timeout compare, parameterized by WAIT_TIMEOUT.

Test Plan:
- Reset release with mem_ready_i=1 and opcode 0x00:
  - Required state sequence: IDLE, FETCH, DECODE, EXECUTE, R_WB, FETCH.
  - R_WB shows reg_write=1, reg_dst=1.
  - instr_count_o reads 1 afterwards.
- lw (0x23) with mem_ready_i low for 3 cycles in MEM_READ:
  - MEM_READ is held 4 cycles with mem_read=1, i_or_d=1.
  - MEM_WB follows with mem_to_reg=1.
  - No bus error.
- bne (0x05):
  - BRANCH drives pc_write_cond=1, branch_ne=1, alu_op=001, pc_source=01.
  - beq (0x04) gives the same with branch_ne=0.
- WAIT_TIMEOUT=4 with mem_ready_i held 0 in FETCH:
  - ERROR entered after 4 wait cycles; bus_error_o=1 and all controls 0.
  - Remains in ERROR until reset pulse; cleared after reset.
- Opcode 0x3F:
  - With macro: TRAP, illegal_op_o=1, counter unchanged.
  - Without macro: DECODE -> FETCH, counter +1.
- CNT_WIDTH=4, run 16 j instructions: instr_count_o wraps to 0; reset mid-JUMP gives state IDLE.
